crc16_rx_ctrl: RTL and testbench
================================

# crc16_rx_ctrl

Receive-side frame checker that sequences the 32-bit-parallel CRC-16 datapath (polynomial x^16+x^12+x^5+1, init 16'hFFFF) over framed word streams. It re-initialises the CRC at each start-of-frame and feeds every accepted word, including the appended CRC word, through the update. At end-of-frame it posts a pass/fail status record through a valid/ready handshake. It sits between the receive word stream and the frame-status consumer.

## Interface
- P_MAX_WORDS, 1024: maximum legal frame length in 32-bit words (2..65535).
- P_RESIDUE, 16'h0000: CRC register value that marks a good frame after its last word.
- i_clk_r  in  1  clock; all logic is on the rising edge.
- i_rst_n_r  in  1  asynchronous, active-low reset.
- i_din_valid_r  in  1  input word valid.
- o_din_ready_r  out  1  block can accept a word.
- i_din_r  in  32  input word, same bit order as the CRC engine's d[31:0].
- i_sop_r  in  1  word is the first of a frame.
- i_eop_r  in  1  word is the last of a frame; carries the CRC.
- o_stat_valid_r  out  1  status record valid.
- i_stat_ready_r  in  1  consumer takes the status record.
- o_stat_pass_r  out  1  final CRC == P_RESIDUE and no overflow.
- o_stat_ovf_r  out  1  frame exceeded P_MAX_WORDS.
- o_stat_len_r  out  16  accepted word count, including the eop word.
- o_stat_crc_r  out  16  final CRC register value.
- o_orphan_cnt_r  out  16  words discarded outside a frame (saturating).
- o_pass_cnt_r / o_fail_cnt_r  out  32 each  frame statistics (see Configuration).

## Operation
- A word is accepted when i_din_valid_r & o_din_ready_r.
- o_din_ready_r = ~(o_stat_valid_r & ~i_stat_ready_r). Input stalls only while an unretrieved record is pending.
- FSM states: IDLE and BODY.
- IDLE:
  - Accepted word with sop: the CRC starts from 16'hFFFF, len = 1, ovf = 0.
  - If eop is also set, the frame completes immediately. Otherwise go to BODY.
  - Accepted word without sop: discard it and increment o_orphan_cnt_r.
- BODY:
  - Each accepted word updates the CRC and increments len.
  - Accepted word with eop completes the frame and returns to IDLE.
  - Accepted word with sop restarts the frame: the CRC is re-seeded from 16'hFFFF with this word, len = 1. The aborted frame is counted as an orphan (+1) and produces no status record.
- Overflow: accepting a word when len == P_MAX_WORDS sets ovf (sticky for the frame). len saturates at P_MAX_WORDS. The CRC keeps updating.
- Frame completion loads the status record: pass = (crc_next == P_RESIDUE) & ~ovf, plus ovf, len and crc_next.
- Status handshake: o_stat_valid_r stays high until i_stat_ready_r is sampled high. If a completion and a retirement happen in the same cycle, the new record replaces the old one and valid stays high.
- All counters saturate at their all-ones value.

## Timing
- Reset (asynchronous assert, synchronous release) drives:
  - state to IDLE and the CRC register to 16'hFFFF;
  - o_stat_valid_r to 0 and all o_stat_* fields to 0;
  - all counters to 0;
  - o_din_ready_r to 1.
- Reset in mid-frame discards the frame with no status record.
- CRC update is single-cycle: the word accepted at edge N is reflected in the register after edge N.
- Status latency: o_stat_valid_r rises on the edge that accepts the eop word, i.e. it is visible in the following cycle.
- Back-to-back frames sustain one word per cycle while i_stat_ready_r is held high. Single-word frames (sop & eop) are legal every cycle.

## Configuration
- CRC16_RX_CTRL_STATS_EN:
  - Defined: o_pass_cnt_r and o_fail_cnt_r count completed frames by o_stat_pass_r, incrementing on the completion edge.
  - Undefined: both ports still exist, are tied to 0, and no counter flops are built.

## Structure
- Shared package crc16_pkg holds:
  - CRC_POLY = 16'h1021;
  - CRC_INIT = 16'hFFFF;
  - the state enum {IDLE, BODY};
  - the status record struct (pass, ovf, len, crc).
- Sub-module crc16_d32_next: a purely combinational next-CRC function (16-bit c, 32-bit d → 16-bit next). It is instantiated once. The controller owns the CRC register.

## Test plan
- After reset: o_din_ready_r = 1, o_stat_valid_r = 0, CRC register = 16'hFFFF.
- Stream a 4-word frame whose eop word is the CRC from the bench's bit-serial golden model, with i_stat_ready_r = 1 → one record: pass = 1, len = 4, crc = 16'h0000, ovf = 0. Repeat with bit 0 of word 2 flipped → pass = 0, len = 4, crc ≠ 0, fail_cnt = 1 (STATS_EN).
- Two valid frames back-to-back while i_stat_ready_r = 0 → first record held, o_din_ready_r = 0 after the first eop, no word lost. Raise ready → the second frame completes, with exactly two records in order.
- Three words without sop, then sop mid-BODY → o_orphan_cnt_r = 4, and only the restarted frame reports.
- P_MAX_WORDS = 4 with a 6-word frame → ovf = 1, pass = 0, len = 4. Assert i_rst_n_r low mid-frame → outputs return to reset values asynchronously and no record is produced.

Source files
------------

// File: rtl/crc16_rx_ctrl_pkg.sv
// Shared CRC-16 receive types: polynomial/seed constants, controller states, frame status record.
package crc16_pkg;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    typedef enum logic {
        IDLE = 1'b0,
        BODY = 1'b1
    } state_t;

    typedef struct packed {
        logic        pass;
        logic        ovf;
        logic [15:0] len;
        logic [15:0] crc;
    } stat_t;

endpackage

// File: rtl/crc16_rx_ctrl_if.sv
// Word-stream input and frame-status output bundle of the CRC-16 receive checker.
// The slave modport is the checker's view; the master modport is the surrounding logic's view.
interface crc16_rx_ctrl_if;

    logic        i_din_valid_r;
    logic        o_din_ready_r;
    logic [31:0] i_din_r;
    logic        i_sop_r;
    logic        i_eop_r;
    logic        o_stat_valid_r;
    logic        i_stat_ready_r;
    logic        o_stat_pass_r;
    logic        o_stat_ovf_r;
    logic [15:0] o_stat_len_r;
    logic [15:0] o_stat_crc_r;

    modport slave (
        input  i_din_valid_r, i_din_r, i_sop_r, i_eop_r, i_stat_ready_r,
        output o_din_ready_r, o_stat_valid_r, o_stat_pass_r, o_stat_ovf_r,
               o_stat_len_r, o_stat_crc_r
    );

    modport master (
        output i_din_valid_r, i_din_r, i_sop_r, i_eop_r, i_stat_ready_r,
        input  o_din_ready_r, o_stat_valid_r, o_stat_pass_r, o_stat_ovf_r,
               o_stat_len_r, o_stat_crc_r
    );

endinterface

// File: rtl/crc16_d32_next.sv
// Combinational CRC-16 (x^16+x^12+x^5+1) advance over one 32-bit word, d[31] consumed first.
// Zero latency, no state, no backpressure.
module crc16_d32_next
    import crc16_pkg::*;
(
    input  logic [15:0] i_c,
    input  logic [31:0] i_d,
    output logic [15:0] o_next
);

    logic [15:0] w_acc;

    // Unrolled bit-serial LFSR; synthesis flattens this into an XOR network.
    always_comb begin
        w_acc = i_c;
        for (int i = 31; i >= 0; i--) begin
            w_acc = {w_acc[14:0], 1'b0} ^ ((w_acc[15] ^ i_d[i]) ? CRC_POLY : 16'h0000);
        end
        o_next = w_acc;
    end

endmodule

// File: rtl/crc16_rx_ctrl.sv
// Receive frame checker: CRC-16 over sop..eop words, pass/fail record out one cycle after eop.
// Input stalls only while a record is pending and unretrieved; optional counters via CRC16_RX_CTRL_STATS_EN.
module crc16_rx_ctrl
    import crc16_pkg::*;
#(
    parameter int          P_MAX_WORDS = 1024,
    parameter logic [15:0] P_RESIDUE   = 16'h0000
) (
    input  logic           i_clk_r,
    input  logic           i_rst_n_r,
    crc16_rx_ctrl_if.slave bus,
    output logic [15:0]    o_orphan_cnt_r,
    output logic [31:0]    o_pass_cnt_r,
    output logic [31:0]    o_fail_cnt_r
);

    localparam logic [15:0] LP_MAX_LEN = 16'(P_MAX_WORDS);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_crc, w_crc_nxt, w_crc_in, w_crc_upd;
    logic [15:0] r_len, w_len_nxt;
    logic        r_ovf, w_ovf_nxt;
    logic        r_stat_vld;
    stat_t       r_stat, w_stat_new;
    logic        w_accept, w_done, w_orphan;
    logic [15:0] r_orphan_cnt;

    assign bus.o_din_ready_r = ~(r_stat_vld & ~bus.i_stat_ready_r);
    assign w_accept          = bus.i_din_valid_r & bus.o_din_ready_r;

    // A sop word always seeds from CRC_INIT, even when it aborts a frame in BODY.
    assign w_crc_in = ((r_state == IDLE) || bus.i_sop_r) ? CRC_INIT : r_crc;

    crc16_d32_next u_crc_next (
        .i_c    (w_crc_in),
        .i_d    (bus.i_din_r),
        .o_next (w_crc_upd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_crc_nxt   = r_crc;
        w_len_nxt   = r_len;
        w_ovf_nxt   = r_ovf;
        w_done      = 1'b0;
        w_orphan    = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    if (bus.i_sop_r) begin
                        w_crc_nxt   = w_crc_upd;
                        w_len_nxt   = 16'd1;
                        w_ovf_nxt   = 1'b0;
                        w_done      = bus.i_eop_r;
                        w_state_nxt = bus.i_eop_r ? IDLE : BODY;
                    end else begin
                        w_orphan = 1'b1;
                    end
                end
                BODY: begin
                    w_crc_nxt   = w_crc_upd;
                    w_done      = bus.i_eop_r;
                    w_state_nxt = bus.i_eop_r ? IDLE : BODY;
                    if (bus.i_sop_r) begin
                        w_orphan  = 1'b1;
                        w_len_nxt = 16'd1;
                        w_ovf_nxt = 1'b0;
                    end else if (r_len == LP_MAX_LEN) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_len_nxt = r_len + 16'd1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    assign w_stat_new = '{pass: (w_crc_upd == P_RESIDUE) & ~w_ovf_nxt,
                          ovf:  w_ovf_nxt,
                          len:  w_len_nxt,
                          crc:  w_crc_upd};

    always_ff @(posedge i_clk_r or negedge i_rst_n_r) begin
        if (!i_rst_n_r) begin
            r_state      <= IDLE;
            r_crc        <= CRC_INIT;
            r_len        <= 16'd0;
            r_ovf        <= 1'b0;
            r_stat_vld   <= 1'b0;
            r_stat       <= '0;
            r_orphan_cnt <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_crc   <= w_crc_nxt;
            r_len   <= w_len_nxt;
            r_ovf   <= w_ovf_nxt;
            // A new completion may overwrite a record retired on this same edge.
            if (w_done) begin
                r_stat     <= w_stat_new;
                r_stat_vld <= 1'b1;
            end else if (bus.i_stat_ready_r) begin
                r_stat_vld <= 1'b0;
            end
            if (w_orphan && (r_orphan_cnt != 16'hFFFF)) begin
                r_orphan_cnt <= r_orphan_cnt + 16'd1;
            end
        end
    end

    assign bus.o_stat_valid_r = r_stat_vld;
    assign bus.o_stat_pass_r  = r_stat.pass;
    assign bus.o_stat_ovf_r   = r_stat.ovf;
    assign bus.o_stat_len_r   = r_stat.len;
    assign bus.o_stat_crc_r   = r_stat.crc;
    assign o_orphan_cnt_r     = r_orphan_cnt;

`ifdef CRC16_RX_CTRL_STATS_EN
    logic [31:0] r_pass_cnt, r_fail_cnt;

    always_ff @(posedge i_clk_r or negedge i_rst_n_r) begin
        if (!i_rst_n_r) begin
            r_pass_cnt <= 32'd0;
            r_fail_cnt <= 32'd0;
        end else if (w_done) begin
            if (w_stat_new.pass) begin
                if (r_pass_cnt != 32'hFFFF_FFFF) r_pass_cnt <= r_pass_cnt + 32'd1;
            end else begin
                if (r_fail_cnt != 32'hFFFF_FFFF) r_fail_cnt <= r_fail_cnt + 32'd1;
            end
        end
    end

    assign o_pass_cnt_r = r_pass_cnt;
    assign o_fail_cnt_r = r_fail_cnt;
`else
    assign o_pass_cnt_r = 32'd0;
    assign o_fail_cnt_r = 32'd0;
`endif

endmodule

// File: tb/tb_crc16_rx_ctrl.sv
// Bench for crc16_rx_ctrl: one instance at default size, one with a 4-word limit for overflow.
module tb_crc16_rx_ctrl;
    import crc16_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    crc16_rx_ctrl_if a ();
    crc16_rx_ctrl_if b ();

    logic [15:0] orph_a, orph_b;
    logic [31:0] pc_a, fc_a, pc_b, fc_b;

    crc16_rx_ctrl #(.P_MAX_WORDS(1024), .P_RESIDUE(16'h0000)) dut (
        .i_clk_r(clk), .i_rst_n_r(rst_n), .bus(a),
        .o_orphan_cnt_r(orph_a), .o_pass_cnt_r(pc_a), .o_fail_cnt_r(fc_a)
    );

    crc16_rx_ctrl #(.P_MAX_WORDS(4), .P_RESIDUE(16'h0000)) dut_b (
        .i_clk_r(clk), .i_rst_n_r(rst_n), .bus(b),
        .o_orphan_cnt_r(orph_b), .o_pass_cnt_r(pc_b), .o_fail_cnt_r(fc_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] q_a[$];
    logic [15:0] q_b[$];
    logic [31:0] fr[$];

    typedef struct {
        logic        vld, sop, eop;
        logic [31:0] din;
        logic        e_vld, e_pass;
        logic [15:0] e_len, e_crc, e_orph;
    } vec_t;
    vec_t tbl[8];

    // Records retired by the consumer, in order (valid & ready seen before the edge).
    always @(negedge clk) begin
        if (a.o_stat_valid_r && a.i_stat_ready_r) q_a.push_back(a.o_stat_len_r);
        if (b.o_stat_valid_r && b.i_stat_ready_r) q_b.push_back(b.o_stat_len_r);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Byte-at-a-time reference CRC (CCITT, MSB first).
    function automatic logic [15:0] m_crc(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        logic [7:0]  by;
        r = c;
        for (int k = 3; k >= 0; k--) begin
            by = w[8*k +: 8];
            r  = r ^ {by, 8'h00};
            for (int j = 0; j < 8; j++) r = r[15] ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] chain(input logic [31:0] w[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (w[i]) c = m_crc(c, w[i]);
        return c;
    endfunction

    task automatic send(input bit sel, input bit sop, input bit eop, input logic [31:0] d);
        bit got;
        got = 1'b0;
        if (sel) begin
            b.i_din_valid_r = 1'b1; b.i_sop_r = sop; b.i_eop_r = eop; b.i_din_r = d;
        end else begin
            a.i_din_valid_r = 1'b1; a.i_sop_r = sop; a.i_eop_r = eop; a.i_din_r = d;
        end
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clk);
            got = sel ? b.o_din_ready_r : a.o_din_ready_r;
            @(posedge clk);
            #1;
        end
        chk("send_accept", {31'd0, got}, 32'd1);
        if (sel) begin
            b.i_din_valid_r = 1'b0; b.i_sop_r = 1'b0; b.i_eop_r = 1'b0;
        end else begin
            a.i_din_valid_r = 1'b0; a.i_sop_r = 1'b0; a.i_eop_r = 1'b0;
        end
    endtask

    task automatic send_frame(input bit sel, input logic [31:0] w[$]);
        foreach (w[i]) send(sel, i == 0, i == w.size() - 1, w[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        a.i_din_valid_r = 0; a.i_sop_r = 0; a.i_eop_r = 0; a.i_din_r = 0; a.i_stat_ready_r = 1;
        b.i_din_valid_r = 0; b.i_sop_r = 0; b.i_eop_r = 0; b.i_din_r = 0; b.i_stat_ready_r = 1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", a.o_din_ready_r, 1);
        chk("rst_valid", a.o_stat_valid_r, 0);
        chk("rst_crc_reg", dut.r_crc, 16'hFFFF);
        chk("rst_fields", {a.o_stat_pass_r, a.o_stat_ovf_r, a.o_stat_len_r, a.o_stat_crc_r}, 0);
        chk("rst_orphan", orph_a, 0);
        chk("rst_cnts", pc_a | fc_a | pc_b | fc_b, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Good 4-word frame, then the same with bit 0 of word 2 flipped
        fr = '{32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF};
        fr.push_back({chain(fr), 16'h0000});
        send_frame(1'b0, fr);
        chk("good_valid", a.o_stat_valid_r, 1);
        chk("good_pass", a.o_stat_pass_r, 1);
        chk("good_len", a.o_stat_len_r, 4);
        chk("good_crc", a.o_stat_crc_r, 16'h0000);
        chk("good_ovf", a.o_stat_ovf_r, 0);
        fr[2] = fr[2] ^ 32'h1;
        send_frame(1'b0, fr);
        chk("bad_pass", a.o_stat_pass_r, 0);
        chk("bad_len", a.o_stat_len_r, 4);
        chk("bad_crc", a.o_stat_crc_r, chain(fr));
        chk("bad_crc_nz", {31'd0, a.o_stat_crc_r != 16'h0000}, 1);
`ifdef CRC16_RX_CTRL_STATS_EN
        chk("pass_cnt", pc_a, 1);
        chk("fail_cnt", fc_a, 1);
`else
        chk("pass_cnt", pc_a, 0);
        chk("fail_cnt", fc_a, 0);
`endif

        // Table: single-word frames, orphans and a 2-word frame, one vector per cycle
        tbl[0] = '{1'b1, 1'b1, 1'b1, 32'hFFFF0000, 1'b1, 1'b1, 16'd1, 16'h0000, 16'd0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 32'h00001234, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 32'h12345678, 1'b1, 1'b0, 16'd1,
                   m_crc(16'hFFFF, 32'h12345678), 16'd1};
        tbl[4] = '{1'b1, 1'b1, 1'b1, 32'hFFFF0000, 1'b1, 1'b1, 16'd1, 16'h0000, 16'd1};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'hCAFEF00D, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd1};
        tbl[6] = '{1'b1, 1'b0, 1'b1, {m_crc(16'hFFFF, 32'hCAFEF00D), 16'h0000},
                   1'b1, 1'b1, 16'd2, 16'h0000, 16'd1};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0, 16'd0, 16'h0000, 16'd2};
        for (int i = 0; i < 8; i++) begin
            a.i_din_valid_r = tbl[i].vld;
            a.i_sop_r       = tbl[i].sop;
            a.i_eop_r       = tbl[i].eop;
            a.i_din_r       = tbl[i].din;
            @(posedge clk);
            #1;
            chk($sformatf("t%0d_valid", i), a.o_stat_valid_r, tbl[i].e_vld);
            chk($sformatf("t%0d_orphan", i), orph_a, tbl[i].e_orph);
            if (tbl[i].e_vld) begin
                chk($sformatf("t%0d_pass", i), a.o_stat_pass_r, tbl[i].e_pass);
                chk($sformatf("t%0d_len", i), a.o_stat_len_r, tbl[i].e_len);
                chk($sformatf("t%0d_crc", i), a.o_stat_crc_r, tbl[i].e_crc);
            end
        end
        a.i_din_valid_r = 0; a.i_sop_r = 0; a.i_eop_r = 0;

        // Back-to-back frames with the consumer stalled
        a.i_stat_ready_r = 1'b0;
        @(posedge clk);
        #1;
        q_a.delete();
        fr = '{32'h11111111, 32'h22222222, 32'h33333333};
        fr.push_back({chain(fr), 16'h0000});
        send_frame(1'b0, fr);
        chk("hold1_valid", a.o_stat_valid_r, 1);
        chk("hold1_len", a.o_stat_len_r, 4);
        chk("hold1_ready", a.o_din_ready_r, 0);
        fr = '{32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        fr.push_back({chain(fr), 16'h0000});
        a.i_din_valid_r = 1'b1; a.i_sop_r = 1'b1; a.i_eop_r = 1'b0; a.i_din_r = fr[0];
        repeat (3) @(posedge clk);
        #1;
        chk("stall_ready", a.o_din_ready_r, 0);
        chk("stall_len", a.o_stat_len_r, 4);
        chk("stall_valid", a.o_stat_valid_r, 1);
        a.i_stat_ready_r = 1'b1;
        @(posedge clk);
        #1;
        a.i_stat_ready_r = 1'b0;
        a.i_din_valid_r = 1'b0; a.i_sop_r = 1'b0;
        chk("retire_valid", a.o_stat_valid_r, 0);
        for (int i = 1; i < 5; i++) send(1'b0, 1'b0, i == 4, fr[i]);
        chk("hold2_valid", a.o_stat_valid_r, 1);
        chk("hold2_len", a.o_stat_len_r, 5);
        chk("hold2_pass", a.o_stat_pass_r, 1);
        a.i_stat_ready_r = 1'b1;
        @(posedge clk);
        #1;
        chk("hold2_retired", a.o_stat_valid_r, 0);
        chk("rec_count", q_a.size(), 2);
        if (q_a.size() == 2) begin
            chk("rec0_len", q_a[0], 4);
            chk("rec1_len", q_a[1], 5);
        end

        // Orphans, then a sop that restarts a frame in BODY
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst2_orphan", orph_a, 0);
        q_a.delete();
        for (int i = 0; i < 3; i++) send(1'b0, 1'b0, 1'b0, 32'hA0A0A0A0 + i);
        chk("orph3", orph_a, 3);
        send(1'b0, 1'b1, 1'b0, 32'h0BADF00D);
        send(1'b0, 1'b0, 1'b0, 32'h0BADBEEF);
        chk("orph_body_valid", a.o_stat_valid_r, 0);
        fr = '{32'h13579BDF, 32'h2468ACE0};
        fr.push_back({chain(fr), 16'h0000});
        send_frame(1'b0, fr);
        chk("orph4", orph_a, 4);
        chk("restart_pass", a.o_stat_pass_r, 1);
        chk("restart_len", a.o_stat_len_r, 3);
        @(posedge clk);
        #1;
        chk("restart_recs", q_a.size(), 1);

        // Overflow on the 4-word-limited instance
        q_b.delete();
        fr = '{32'h00000001, 32'h00000002, 32'h00000003, 32'h00000004, 32'h00000005};
        fr.push_back({chain(fr), 16'h0000});
        send_frame(1'b1, fr);
        chk("ovf_valid", b.o_stat_valid_r, 1);
        chk("ovf_flag", b.o_stat_ovf_r, 1);
        chk("ovf_pass", b.o_stat_pass_r, 0);
        chk("ovf_len", b.o_stat_len_r, 4);
        chk("ovf_crc", b.o_stat_crc_r, 16'h0000);
        @(posedge clk);
        #1;
        q_b.delete();

        // Asynchronous reset in mid-frame
        send(1'b1, 1'b1, 1'b0, 32'hFEEDFACE);
        send(1'b1, 1'b0, 1'b0, 32'h01020304);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_len", b.o_stat_len_r, 0);
        chk("arst_ovf", b.o_stat_ovf_r, 0);
        chk("arst_ready", b.o_din_ready_r, 1);
        chk("arst_crc_reg", dut_b.r_crc, 16'hFFFF);
        chk("arst_orphan_a", orph_a, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("arst_no_valid", b.o_stat_valid_r, 0);
        send(1'b1, 1'b0, 1'b1, 32'h05060708);
        chk("arst_tail_orphan", orph_b, 1);
        chk("arst_tail_valid", b.o_stat_valid_r, 0);
        @(posedge clk);
        #1;
        chk("arst_no_record", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
